be_sdpb: RTL and testbench

BE_SDPB -- requirements
Module: be_sdpb

---
 rtl/be_sdpb_pkg.sv | 12 +
 rtl/be_sdpb_if.sv | 33 +++
 rtl/be_sdpb_lane.sv | 57 +++++
 rtl/be_sdpb.sv | 40 ++++
 tb/tb_be_sdpb.sv | 123 ++++++++++++
 5 files changed

// File: rtl/be_sdpb_pkg.sv
// ----------------------------------------------------------------------------
// be_sdpb_pkg
// Shared sizing constants for the byte-enabled single-address block RAM.
//   BYTE_COUNT : number of byte lanes in one word
//   BYTE_WIDTH : bits per byte lane
//   DATA_WIDTH : word width (BYTE_COUNT * BYTE_WIDTH)
// ----------------------------------------------------------------------------
package be_sdpb_pkg;
   localparam int BYTE_COUNT = 4;
   localparam int BYTE_WIDTH = 8;
   localparam int DATA_WIDTH = BYTE_COUNT * BYTE_WIDTH;
endpackage

// File: rtl/be_sdpb_if.sv
// ----------------------------------------------------------------------------
// be_sdpb_if
// Bus bundle for be_sdpb.
//   write_enable : per-byte write strobes, bit i covers data_in[8i+7:8i]
//   address      : shared word address for write and read
//   data_in      : write data
//   data_out     : registered read data (one cycle after address)
// Modports: master drives the request side, slave (the RAM) drives data_out.
// ----------------------------------------------------------------------------
interface be_sdpb_if
   import be_sdpb_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH = 8
);
   logic [BYTE_COUNT-1:0]       write_enable;
   logic [ADDRESS_BITWIDTH-1:0] address;
   logic [DATA_WIDTH-1:0]       data_in;
   logic [DATA_WIDTH-1:0]       data_out;

   modport master (
      output write_enable,
      output address,
      output data_in,
      input  data_out
   );

   modport slave (
      input  write_enable,
      input  address,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/be_sdpb_lane.sv
// ----------------------------------------------------------------------------
// be_sdpb_lane
// One 8-bit wide RAM lane with a single write enable and a registered read.
// Optional feature macro: BE_SDPB_WRITE_FIRST_EN
//   undefined (default) : same-address read during write returns old byte
//   defined             : same-address read during write returns new byte
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high; clears dout_o, blocks the write
//   we_i    : write enable for this lane
//   addr_i  : word address
//   din_i   : write byte
//   dout_o  : registered read byte
// ----------------------------------------------------------------------------
module be_sdpb_lane
   import be_sdpb_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we_i,
   input  logic [ADDRESS_BITWIDTH-1:0] addr_i,
   input  logic [BYTE_WIDTH-1:0]       din_i,
   output logic [BYTE_WIDTH-1:0]       dout_o
);
   localparam int DEPTH = 2 ** ADDRESS_BITWIDTH;

   // Contents power up as zero independent of rst so that flag bits kept in
   // the array start cleared; reset never touches the array.
   logic [BYTE_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
   logic [BYTE_WIDTH-1:0] dout_q;
   logic [BYTE_WIDTH-1:0] rd_d;

   always_comb begin
      rd_d = mem_q[addr_i];
`ifdef BE_SDPB_WRITE_FIRST_EN
      // Bypass so a colliding read sees the byte being written.
      if (we_i) begin
         rd_d = din_i;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         if (we_i) begin
            mem_q[addr_i] <= din_i;
         end
         dout_q <= rd_d;
      end
   end

   assign dout_o = dout_q;
endmodule

// File: rtl/be_sdpb.sv
// ----------------------------------------------------------------------------
// be_sdpb
// 2**ADDRESS_BITWIDTH x 32-bit block RAM with per-byte write enables and a
// shared read/write address. Read happens every cycle with one cycle latency.
// Built from BYTE_COUNT be_sdpb_lane instances so each lane maps onto a
// byte-wide BSRAM slice.
// Optional feature macro: BE_SDPB_WRITE_FIRST_EN (write-first collision
// behaviour; default read-first).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high; clears data_out, suppresses writes,
//          memory contents preserved
//   bus  : be_sdpb_if.slave (write_enable, address, data_in, data_out)
// ----------------------------------------------------------------------------
module be_sdpb
   import be_sdpb_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   be_sdpb_if.slave      bus
);
   logic [DATA_WIDTH-1:0] rd_word;

   for (genvar g = 0; g < BYTE_COUNT; g++) begin : g_lane
      be_sdpb_lane #(
         .ADDRESS_BITWIDTH(ADDRESS_BITWIDTH)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .we_i   (bus.write_enable[g]),
         .addr_i (bus.address),
         .din_i  (bus.data_in[g*BYTE_WIDTH +: BYTE_WIDTH]),
         .dout_o (rd_word[g*BYTE_WIDTH +: BYTE_WIDTH])
      );
   end

   assign bus.data_out = rd_word;
endmodule

// File: tb/tb_be_sdpb.sv
module tb_be_sdpb;
   import be_sdpb_pkg::*;

   logic clk = 1'b0;
   logic rst;

   be_sdpb_if #(.ADDRESS_BITWIDTH(8)) bus ();

   be_sdpb #(.ADDRESS_BITWIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] model_mem [256];
   logic [31:0] sb_q [$];

   task automatic check(input string tag, input logic [31:0] exp);
      n_assert++;
      assert (bus.data_out === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, bus.data_out, exp);
      end
   endtask

   // Drive one cycle (caller is at a negedge), predict, then compare the
   // result just after the edge and again at the following negedge (hold).
   task automatic step(input string tag, input logic r, input logic [3:0] we,
                       input logic [7:0] a, input logic [31:0] d);
      logic [31:0] old_w, merged, exp, got;
      rst              = r;
      bus.write_enable = we;
      bus.address      = a;
      bus.data_in      = d;
      old_w  = model_mem[a];
      merged = old_w;
      for (int i = 0; i < 4; i++)
         if (we[i]) merged[8*i +: 8] = d[8*i +: 8];
`ifdef BE_SDPB_WRITE_FIRST_EN
      exp = r ? 32'h0 : merged;
`else
      exp = r ? 32'h0 : old_w;
`endif
      if (!r) model_mem[a] = merged;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check(tag, got);
      @(negedge clk);
      check({tag, "_hold"}, got);
   endtask

   initial begin
      logic [31:0] exp_col;
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
      rst = 1'b1;
      bus.write_enable = 4'h0;
      bus.address      = 8'h00;
      bus.data_in      = 32'h0;
      @(negedge clk);

      step("reset0", 1'b1, 4'h0, 8'h00, 32'h0);
      check("reset0_const", 32'h0);
      step("reset1", 1'b1, 4'h0, 8'h00, 32'h0);

      step("rd00", 1'b0, 4'h0, 8'h00, 32'h0);
      check("rd00_const", 32'h0);

      step("wr05_full", 1'b0, 4'hF, 8'h05, 32'hDEADBEEF);
      step("rd05_a", 1'b0, 4'h0, 8'h05, 32'h0);
      check("rd05_a_const", 32'hDEADBEEF);

      step("wr05_mask5", 1'b0, 4'h5, 8'h05, 32'h11223344);
      step("rd05_b", 1'b0, 4'h0, 8'h05, 32'h0);
      check("rd05_b_const", 32'hDE22BE44);

`ifdef BE_SDPB_WRITE_FIRST_EN
      exp_col = 32'hCAFEF00D;
`else
      exp_col = 32'h00000000;
`endif
      step("wr07_collide", 1'b0, 4'hF, 8'h07, 32'hCAFEF00D);
      check("wr07_collide_const", exp_col);
      step("rd07", 1'b0, 4'h0, 8'h07, 32'h0);
      check("rd07_const", 32'hCAFEF00D);

      step("rst_wr05", 1'b1, 4'hF, 8'h05, 32'hFFFFFFFF);
      check("rst_wr05_const", 32'h0);
      step("rd05_after_rst", 1'b0, 4'h0, 8'h05, 32'h0);
      check("rd05_after_rst_const", 32'hDE22BE44);

      step("noop_we0", 1'b0, 4'h0, 8'h07, 32'h12345678);
      step("rd07_unchanged", 1'b0, 4'h0, 8'h07, 32'h0);
      check("rd07_unchanged_const", 32'hCAFEF00D);

      step("wrFF", 1'b0, 4'hF, 8'hFF, 32'hA5A5C3C3);
      step("wr00", 1'b0, 4'hF, 8'h00, 32'h5A5A3C3C);
      step("b2b_FF_0", 1'b0, 4'h0, 8'hFF, 32'h0);
      check("b2b_FF_0_const", 32'hA5A5C3C3);
      step("b2b_00", 1'b0, 4'h0, 8'h00, 32'h0);
      check("b2b_00_const", 32'h5A5A3C3C);
      step("b2b_FF_1", 1'b0, 4'h0, 8'hFF, 32'h0);
      check("b2b_FF_1_const", 32'hA5A5C3C3);

      for (int k = 0; k < 60; k++) begin
         logic       r;
         logic [7:0] a;
         r = ($urandom_range(0, 9) == 0);
         a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
         step("rand", r, 4'($urandom_range(0, 15)), a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
